// File: rtl/uart_tx_feeder.sv
// Byte FIFO in front of a UART transmitter: the host pushes bursts and the
// feeder hands bytes to the UART one at a time, paced by its busy output.
module uart_tx_feeder #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = $clog2(DEPTH),
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  tx_rx_enable,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_W:0]       count,
  output logic                  overflow,
  output logic                  tx_rx_start,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  busy,
  output logic                  sent
);

  localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0]     r_wr_ptr;
  logic [ADDR_W-1:0]     r_rd_ptr;
  logic [ADDR_W:0]       r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_overflow;
  logic                  r_start;
  logic                  r_sent;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic [TMR_W-1:0]      r_timer;

  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_W:0]       w_count_next;

  // Full is the registered flag, so a push while full is refused even when
  // the same edge pops a byte out.
  assign w_push = wr_en & ~r_full;
  assign w_pop  = (r_state == IDLE) & ~r_empty & ~busy;
  assign w_count_next = r_count + {{ADDR_W{1'b0}}, w_push} - {{ADDR_W{1'b0}}, w_pop};

  always_ff @(posedge clk) begin
    if (!tx_rx_enable && w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_rx_enable) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (wr_en && r_full) begin
        r_overflow <= 1'b1;
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == FULL_CNT);
      r_empty <= (w_count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_rx_enable) begin
      r_state   <= IDLE;
      r_start   <= 1'b0;
      r_sent    <= 1'b0;
      r_tx_data <= '0;
      r_timer   <= '0;
    end else begin
      r_start <= 1'b0;
      r_sent  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_tx_data <= r_mem[r_rd_ptr];
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          r_start <= 1'b1;
          r_timer <= '0;
          r_state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // A UART that finishes before busy is ever seen must not stall us.
          if (busy || (r_timer == TMR_LAST)) begin
            r_state <= WAIT_DONE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!busy) begin
            r_sent  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign full        = r_full;
  assign empty       = r_empty;
  assign count       = r_count;
  assign overflow    = r_overflow;
  assign tx_rx_start = r_start;
  assign tx_data     = r_tx_data;
  assign sent        = r_sent;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a small UART busy model and a
// monitor that records every byte handed over on a start pulse.
module tb_uart_tx_feeder;

  logic       clk = 1'b0;
  logic       tx_rx_enable;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       tx_rx_start;
  logic [7:0] tx_data;
  logic       busy;
  logic       sent;

  uart_tx_feeder dut (
    .clk          (clk),
    .tx_rx_enable (tx_rx_enable),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .tx_rx_start  (tx_rx_start),
    .tx_data      (tx_data),
    .busy         (busy),
    .sent         (sent)
  );

  always #5 clk = ~clk;

  // UART model: busy rises on the edge that samples start and stays high 6 cycles
  logic       model_en;
  logic       force_busy;
  int         model_cnt = 0;
  assign busy = force_busy | (model_cnt != 0);

  always @(posedge clk) begin
    if (model_en && tx_rx_start && model_cnt == 0) model_cnt <= 6;
    else if (model_cnt != 0) model_cnt <= model_cnt - 1;
  end

  int         n_start = 0;
  int         n_sent  = 0;
  int         n_viol  = 0;
  logic [7:0] rx_q[$];

  always @(posedge clk) begin
    if (tx_rx_start) begin
      n_start <= n_start + 1;
      rx_q.push_back(tx_data);
      if (busy) n_viol <= n_viol + 1;
    end
    if (sent) n_sent <= n_sent + 1;
  end

  typedef struct {
    logic [7:0] wr_data;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t burst[5];
  vec_t slow[20];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic do_reset();
    tx_rx_enable = 1'b1;
    step(2);
    tx_rx_enable = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic wait_start(input string name);
    int k;
    k = 0;
    while (tx_rx_start !== 1'b1 && k < 50) begin
      step(1);
      k++;
    end
    chk(name, 32'(k < 50), 32'd1);
  endtask

  int base_start, base_sent, base_rx;

  initial begin
    burst[0] = '{8'h01, 8'h01};
    burst[1] = '{8'h02, 8'h02};
    burst[2] = '{8'h03, 8'h03};
    burst[3] = '{8'h04, 8'h04};
    burst[4] = '{8'h05, 8'h05};
    for (int i = 0; i < 20; i++) slow[i] = '{8'(8'h40 + 3 * i), 8'(8'h40 + 3 * i)};

    tx_rx_enable = 1'b1;
    wr_en = 1'b0;
    wr_data = 8'h00;
    model_en = 1'b1;
    force_busy = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset state
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_start", 32'(tx_rx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_sent", 32'(sent), 32'd0);

    // Single byte: start visible two cycles after the write edge
    base_sent = n_sent;
    push(8'hA5);
    chk("a5_count_after_write", 32'(count), 32'd1);
    chk("a5_empty_after_write", 32'(empty), 32'd0);
    chk("a5_start_n0", 32'(tx_rx_start), 32'd0);
    step(1);
    chk("a5_start_n1", 32'(tx_rx_start), 32'd0);
    chk("a5_empty_after_pop", 32'(empty), 32'd1);
    chk("a5_tx_data_issue", 32'(tx_data), 32'hA5);
    step(1);
    chk("a5_start_n2", 32'(tx_rx_start), 32'd1);
    chk("a5_tx_data_start", 32'(tx_data), 32'hA5);
    step(1);
    chk("a5_start_one_cycle", 32'(tx_rx_start), 32'd0);
    step(30);
    chk("a5_sent_once", 32'(n_sent - base_sent), 32'd1);

    // Back-to-back burst through the busy model
    base_start = n_start;
    base_rx = rx_q.size();
    for (int i = 0; i < 5; i++) push(burst[i].wr_data);
    step(150);
    chk("burst_starts", 32'(n_start - base_start), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("burst_rx%0d", i), 32'(rx_q[base_rx + i]), 32'(burst[i].exp_rx));
    end
    chk("burst_no_start_while_busy", 32'(n_viol), 32'd0);

    // Busy held: fill, overflow on 17th, then drain exactly 16
    force_busy = 1'b1;
    base_start = n_start;
    base_rx = rx_q.size();
    for (int i = 0; i < 17; i++) begin
      push(8'(8'h10 + i));
      if (i == 15) begin
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count16", 32'(count), 32'd16);
        chk("fill_no_overflow_yet", 32'(overflow), 32'd0);
      end
    end
    chk("fill_overflow", 32'(overflow), 32'd1);
    chk("fill_count_held", 32'(count), 32'd16);
    chk("fill_no_start", 32'(n_start - base_start), 32'd0);
    force_busy = 1'b0;
    step(300);
    chk("fill_drain_starts", 32'(n_start - base_start), 32'd16);
    chk("fill_first_rx", 32'(rx_q[base_rx]), 32'h10);
    chk("fill_last_rx", 32'(rx_q[base_rx + 15]), 32'h1F);
    chk("fill_empty_after", 32'(empty), 32'd1);

    // Full FIFO, push on the same edge as the pop decision
    do_reset();
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
    chk("popedge_full", 32'(full), 32'd1);
    base_start = n_start;
    base_rx = rx_q.size();
    force_busy = 1'b0;
    push(8'hEE);
    chk("popedge_count15", 32'(count), 32'd15);
    chk("popedge_overflow", 32'(overflow), 32'd1);
    chk("popedge_full_clear", 32'(full), 32'd0);
    chk("popedge_tx_data", 32'(tx_data), 32'h20);
    step(300);
    chk("popedge_starts", 32'(n_start - base_start), 32'd16);
    chk("popedge_last_rx", 32'(rx_q[base_rx + 15]), 32'h2F);

    // Reset while waiting for busy to fall, 3 bytes still queued
    model_en = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'h60 + i));
    force_busy = 1'b1;
    step(2);
    chk("abort_count_queued", 32'(count), 32'd3);
    tx_rx_enable = 1'b1;
    step(1);
    tx_rx_enable = 1'b0;
    chk("abort_count", 32'(count), 32'd0);
    chk("abort_empty", 32'(empty), 32'd1);
    chk("abort_start", 32'(tx_rx_start), 32'd0);
    chk("abort_overflow", 32'(overflow), 32'd0);
    force_busy = 1'b0;
    base_start = n_start;
    step(30);
    chk("abort_no_more_starts", 32'(n_start - base_start), 32'd0);

    // Timeout path, busy never rises; 20 bytes with pointer wrap
    base_start = n_start;
    base_sent = n_sent;
    base_rx = rx_q.size();
    push(slow[0].wr_data);
    wait_start("timeout_first_start");
    step(4);
    chk("timeout_sent_not_yet", 32'(sent), 32'd0);
    step(1);
    chk("timeout_sent_pulse", 32'(sent), 32'd1);
    for (int i = 1; i < 20; i++) begin
      push(slow[i].wr_data);
      step(1);
    end
    step(200);
    chk("timeout_starts", 32'(n_start - base_start), 32'd20);
    chk("timeout_sents", 32'(n_sent - base_sent), 32'd20);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("timeout_rx%0d", i), 32'(rx_q[base_rx + i]), 32'(slow[i].exp_rx));
    end
    chk("timeout_overflow", 32'(overflow), 32'd0);
    chk("timeout_empty", 32'(empty), 32'd1);
    chk("no_start_while_busy", 32'(n_viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
